// File: rtl/rom_arbiter.sv
//==============================================================================
// Module      : rom_arbiter
// Description : Two-master, one-slave bus arbiter. Fair alternation on
//               contention, one-cycle strobe-low release gap between grants,
//               and a watchdog that aborts a transfer the slave never answers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rom_arbiter #(
    parameter int DAT_WIDTH = 32,
    parameter int ADR_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [ADR_WIDTH-1:0] m0_adr_i,
    input  logic [DAT_WIDTH-1:0] m0_dat_i,
    output logic [DAT_WIDTH-1:0] m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [ADR_WIDTH-1:0] m1_adr_i,
    input  logic [DAT_WIDTH-1:0] m1_dat_i,
    output logic [DAT_WIDTH-1:0] m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [ADR_WIDTH-1:0] s_adr_o,
    output logic [DAT_WIDTH-1:0] s_dat_o,
    input  logic [DAT_WIDTH-1:0] s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i
);

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT0  = 3'd1,
        S_GRANT1  = 3'd2,
        S_ABORT   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last;       // master granted most recently (1 = m1)
    logic       w_last_nxt;
    logic [7:0] r_cnt;        // unanswered strobed cycles in current grant
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_cnt_inc;
    logic       w_sel;        // master owning the bus in GRANT/ABORT
    logic       w_sel_stb;

    // In ABORT the owner is whoever was granted last, so r_last identifies it.
    assign w_sel     = (r_state == S_GRANT1) || ((r_state == S_ABORT) && r_last);
    assign w_sel_stb = w_sel ? m1_stb_i : m0_stb_i;
    assign w_cnt_inc = r_cnt + 8'd1;

    // State, fairness pointer and watchdog counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: arbitration in IDLE, completion/watchdog in GRANT, drain in ABORT.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (m0_stb_i && m1_stb_i) begin
                    // Contention goes to whoever did not win last time.
                    if (r_last) begin
                        w_state_nxt = S_GRANT0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_GRANT1;
                        w_last_nxt  = 1'b1;
                    end
                    w_cnt_nxt = 8'd0;
                end else if (m0_stb_i) begin
                    w_state_nxt = S_GRANT0;
                    w_last_nxt  = 1'b0;
                    w_cnt_nxt   = 8'd0;
                end else if (m1_stb_i) begin
                    w_state_nxt = S_GRANT1;
                    w_last_nxt  = 1'b1;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_GRANT0, S_GRANT1: begin
                if (!w_sel_stb) begin
                    w_state_nxt = S_RELEASE;
                end else if (!s_ack_i && !s_err_i) begin
                    // Abort on the edge that completes the TIMEOUT-th silent
                    // strobed cycle, so the slave sees exactly TIMEOUT of them.
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == C_TIMEOUT) begin
                        w_state_nxt = S_ABORT;
                    end
                end
            end
            S_ABORT: begin
                if (!w_sel_stb) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus steering: the owner is wired straight through; everything else is 0.
    always_comb begin
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        // Outputs are forced quiet while reset is asserted, even mid-transfer.
        if (!rst_i) begin
            case (r_state)
                S_GRANT0: begin
                    s_stb_o  = m0_stb_i;
                    s_we_o   = m0_we_i;
                    s_adr_o  = m0_adr_i;
                    s_dat_o  = m0_dat_i;
                    m0_ack_o = s_ack_i;
                    m0_err_o = s_err_i;
                    m0_dat_o = s_dat_i;
                end
                S_GRANT1: begin
                    s_stb_o  = m1_stb_i;
                    s_we_o   = m1_we_i;
                    s_adr_o  = m1_adr_i;
                    s_dat_o  = m1_dat_i;
                    m1_ack_o = s_ack_i;
                    m1_err_o = s_err_i;
                    m1_dat_o = s_dat_i;
                end
                S_ABORT: begin
                    if (r_last) begin
                        m1_err_o = m1_stb_i;
                    end else begin
                        m0_err_o = m0_stb_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
//==============================================================================
// Module      : tb_rom_arbiter
// Description : Self-checking bench for rom_arbiter: directed scenarios with
//               literal expectations plus a randomized run, all outputs compared
//               every cycle against a transaction-level model of the arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rom_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Driven stimulus
    logic          rst = 1'b1;
    logic [1:0]    m_stb = 2'b00;
    logic [1:0]    m_we  = 2'b00;
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_dat [2];
    logic          r_sack = 1'b0;
    logic          r_serr = 1'b0;
    logic [DW-1:0] s_dat_in = '0;

    // Values to apply just after the next rising edge
    logic          n_rst = 1'b1;
    logic [1:0]    n_stb = 2'b00;
    logic [1:0]    n_we  = 2'b00;
    logic [AW-1:0] n_adr [2];
    logic [DW-1:0] n_dat [2];
    logic          n_sack = 1'b0;
    logic          n_serr = 1'b0;
    logic [DW-1:0] n_sdat = '0;

    // DUT outputs
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_ack, s_err;

    // The slave only answers while it is being strobed.
    assign s_ack = s_stb_o & r_sack;
    assign s_err = s_stb_o & r_serr;

    rom_arbiter #(.DAT_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .m0_stb_i(m_stb[0]),
        .m0_we_i (m_we[0]),
        .m0_adr_i(m_adr[0]),
        .m0_dat_i(m_dat[0]),
        .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_stb_i(m_stb[1]),
        .m1_we_i (m_we[1]),
        .m1_adr_i(m_adr[1]),
        .m1_dat_i(m_dat[1]),
        .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_in),
        .s_ack_i (s_ack),
        .s_err_i (s_err)
    );

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: who owns the bus, whether the watchdog fired,
    // whether a release gap is pending, and how long the slave has been silent.
    int own    = -1;
    bit abrt   = 1'b0;
    bit gap    = 1'b0;
    int last_w = 1;
    int waited = 0;

    // Bench slave bookkeeping
    int slv_cnt = 0;
    int slv_lat = 1;
    bit slv_er  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int w;
        if (rst) begin
            own = -1; abrt = 1'b0; gap = 1'b0; last_w = 1; waited = 0;
        end else if (gap) begin
            gap = 1'b0;
        end else if (own < 0) begin
            w = -1;
            if (m_stb[0] && m_stb[1]) w = (last_w == 0) ? 1 : 0;
            else if (m_stb[0])        w = 0;
            else if (m_stb[1])        w = 1;
            if (w >= 0) begin
                own = w; last_w = w; waited = 0; abrt = 1'b0;
            end
        end else if (!m_stb[own]) begin
            own = -1; abrt = 1'b0; gap = 1'b1;
        end else if (!abrt && !r_sack && !r_serr) begin
            waited++;
            if (waited == TO) abrt = 1'b1;
        end
    endtask

    task automatic compare();
        logic          e_stb, e_we;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_wd, e_rd0, e_rd1;
        logic [1:0]    e_ack, e_err;
        e_stb = 1'b0; e_we = 1'b0; e_adr = '0; e_wd = '0;
        e_rd0 = '0; e_rd1 = '0; e_ack = 2'b00; e_err = 2'b00;
        if (!rst && own >= 0) begin
            if (!abrt) begin
                e_stb = m_stb[own];
                e_we  = m_we[own];
                e_adr = m_adr[own];
                e_wd  = m_dat[own];
                e_ack[own] = r_sack & e_stb;
                e_err[own] = r_serr & e_stb;
                if (own == 0) e_rd0 = s_dat_in;
                else          e_rd1 = s_dat_in;
            end else begin
                e_err[own] = m_stb[own];
            end
        end
        chk("s_stb_o",  32'(s_stb_o),  32'(e_stb));
        chk("s_we_o",   32'(s_we_o),   32'(e_we));
        chk("s_adr_o",  32'(s_adr_o),  32'(e_adr));
        chk("s_dat_o",  32'(s_dat_o),  32'(e_wd));
        chk("m0_ack_o", 32'(m0_ack_o), 32'(e_ack[0]));
        chk("m0_err_o", 32'(m0_err_o), 32'(e_err[0]));
        chk("m0_dat_o", 32'(m0_dat_o), 32'(e_rd0));
        chk("m1_ack_o", 32'(m1_ack_o), 32'(e_ack[1]));
        chk("m1_err_o", 32'(m1_err_o), 32'(e_err[1]));
        chk("m1_dat_o", 32'(m1_dat_o), 32'(e_rd1));
    endtask

    // One clock: advance model at the edge, apply next inputs, check at negedge.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        rst      = n_rst;
        m_stb    = n_stb;
        m_we     = n_we;
        m_adr[0] = n_adr[0]; m_adr[1] = n_adr[1];
        m_dat[0] = n_dat[0]; m_dat[1] = n_dat[1];
        r_sack   = n_sack;
        r_serr   = n_serr;
        s_dat_in = n_sdat;
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        n_rst = 1'b1; n_stb = 2'b00; n_sack = 1'b0; n_serr = 1'b0;
        step();
        n_rst = 1'b0;
        step();
    endtask

    // Slave: answers after slv_lat strobed cycles; rerolls between transfers.
    task automatic slave_plan(input bit rnd);
        if (s_stb_o) begin
            slv_cnt++;
        end else begin
            slv_cnt = 0;
            if (rnd) begin
                slv_lat = ($urandom % 8 == 0) ? 255 : 1 + int'($urandom % 3);
                slv_er  = ($urandom % 5 == 0);
            end else begin
                slv_lat = 1; slv_er = 1'b0;
            end
        end
        n_sack = (slv_cnt >= slv_lat) && !slv_er;
        n_serr = (slv_cnt >= slv_lat) && slv_er;
        n_sdat = $urandom;
    endtask

    initial begin : main
        int hi;
        int low_run;
        bit prev;
        int g[$];
        int gaps[$];
        logic a, e;

        m_adr[0] = '0; m_adr[1] = '0; m_dat[0] = '0; m_dat[1] = '0;
        n_adr[0] = '0; n_adr[1] = '0; n_dat[0] = '0; n_dat[1] = '0;

        // Reset and first idle cycle
        step();
        step();
        chk("rst_s_stb", 32'(s_stb_o), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack_o), 32'd0);
        n_rst = 1'b0;
        step();
        chk("idle_s_adr", 32'(s_adr_o), 32'd0);

        // Single read by m0, ack one cycle after strobe
        n_stb[0] = 1'b1; n_we[0] = 1'b0; n_adr[0] = 32'h8; n_dat[0] = 32'h1234_5678;
        step();                                     // cycle k: IDLE samples stb
        chk("rd_k_s_stb", 32'(s_stb_o), 32'd0);
        step();                                     // k+1: strobe to slave
        chk("rd_k1_s_stb", 32'(s_stb_o), 32'd1);
        chk("rd_k1_s_adr", 32'(s_adr_o), 32'h8);
        chk("rd_k1_m0_ack", 32'(m0_ack_o), 32'd0);
        n_sack = 1'b1; n_sdat = 32'hDEAD_BEEF;
        step();                                     // k+2: ack
        chk("rd_k2_m0_ack", 32'(m0_ack_o), 32'd1);
        chk("rd_k2_m0_dat", 32'(m0_dat_o), 32'hDEAD_BEEF);
        chk("rd_k2_m1_ack", 32'(m1_ack_o), 32'd0);
        chk("rd_k2_m1_dat", 32'(m1_dat_o), 32'd0);
        n_stb[0] = 1'b0; n_sack = 1'b0;
        step();                                     // master drops stb
        n_stb[0] = 1'b1;                            // and re-requests at once
        step();                                     // release
        chk("rd_release_s_stb", 32'(s_stb_o), 32'd0);
        step();                                     // idle, re-arbitration
        chk("rd_idle_s_stb", 32'(s_stb_o), 32'd0);
        step();
        chk("rd_regrant_s_stb", 32'(s_stb_o), 32'd1);
        n_stb[0] = 1'b0;
        step(); step(); step();

        // Contention: both masters request continuously, re-raising right
        // after each completed transfer.
        do_reset();
        n_adr[0] = 32'h100; n_adr[1] = 32'h200; n_we = 2'b00;
        n_stb = 2'b11;
        prev = 1'b0; low_run = 0;
        for (int c = 0; c < 80; c++) begin
            slave_plan(1'b0);
            a = m0_ack_o; e = m0_err_o;
            n_stb[0] = !(m_stb[0] && (a || e));
            a = m1_ack_o; e = m1_err_o;
            n_stb[1] = !(m_stb[1] && (a || e));
            step();
            if (s_stb_o) begin
                if (!prev) begin
                    if (g.size() > 0) gaps.push_back(low_run);
                    g.push_back((s_adr_o == 32'h200) ? 1 : 0);
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev = s_stb_o;
        end
        chk("cont_n_grants", 32'(g.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++)
            chk("cont_grant_owner", 32'((k < g.size()) ? g[k] : 99), 32'(k % 2));
        // Low gap = drop cycle + one release cycle + one arbitration cycle.
        for (int k = 0; k < 3; k++)
            chk("cont_gap", 32'((k < gaps.size()) ? gaps[k] : 99), 32'd3);

        // Timeout: m1 read, slave silent
        do_reset();
        n_stb[1] = 1'b1; n_we[1] = 1'b0; n_adr[1] = 32'h40;
        n_sack = 1'b0; n_serr = 1'b0;
        step();
        hi = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (s_stb_o) hi++;
            else if (hi > 0) break;
        end
        chk("to_strobed_cycles", 32'(hi), 32'd16);
        chk("to_m1_err", 32'(m1_err_o), 32'd1);
        chk("to_m1_ack", 32'(m1_ack_o), 32'd0);
        step();
        chk("to_m1_err_held", 32'(m1_err_o), 32'd1);
        n_stb[1] = 1'b0;
        step();
        chk("to_m1_err_drop", 32'(m1_err_o), 32'd0);
        step();
        chk("to_release_s_stb", 32'(s_stb_o), 32'd0);
        step();

        // Write to a read-only slave, then a normal read
        n_stb[0] = 1'b1; n_we[0] = 1'b1; n_adr[0] = 32'h20; n_dat[0] = 32'hCAFE_F00D;
        step();
        step();
        chk("wr_s_we", 32'(s_we_o), 32'd1);
        chk("wr_s_dat", 32'(s_dat_o), 32'hCAFE_F00D);
        n_serr = 1'b1;
        step();
        chk("wr_m0_err", 32'(m0_err_o), 32'd1);
        chk("wr_m0_ack", 32'(m0_ack_o), 32'd0);
        step();
        chk("wr_m0_err_held", 32'(m0_err_o), 32'd1);
        n_stb[0] = 1'b0; n_serr = 1'b0;
        step(); step(); step();
        n_stb[0] = 1'b1; n_we[0] = 1'b0;
        step(); step();
        n_sack = 1'b1; n_sdat = 32'h0BAD_F00D;
        step();
        chk("wr_next_m0_ack", 32'(m0_ack_o), 32'd1);
        chk("wr_next_m0_err", 32'(m0_err_o), 32'd0);
        n_stb[0] = 1'b0; n_sack = 1'b0;
        step(); step(); step();

        // Reset in the middle of an acked m1 transfer
        n_stb[1] = 1'b1; n_adr[1] = 32'h300; n_adr[0] = 32'h500;
        step(); step();
        n_sack = 1'b1;
        step();
        chk("mid_m1_ack", 32'(m1_ack_o), 32'd1);
        n_rst = 1'b1; n_sack = 1'b0; n_stb = 2'b11;
        step();
        chk("mid_rst_s_stb", 32'(s_stb_o), 32'd0);
        chk("mid_rst_m1_ack", 32'(m1_ack_o), 32'd0);
        chk("mid_rst_s_adr", 32'(s_adr_o), 32'd0);
        n_rst = 1'b0;
        step();
        chk("mid_idle_s_stb", 32'(s_stb_o), 32'd0);
        chk("mid_idle_m1_dat", 32'(m1_dat_o), 32'd0);
        step();
        chk("mid_m0_wins_stb", 32'(s_stb_o), 32'd1);
        chk("mid_m0_wins_adr", 32'(s_adr_o), 32'h500);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                a = (i == 0) ? m0_ack_o : m1_ack_o;
                e = (i == 0) ? m0_err_o : m1_err_o;
                if (m_stb[i]) begin
                    if (a || e || ($urandom % 60 == 0)) n_stb[i] = 1'b0;
                end else if ($urandom % 3 == 0) begin
                    n_stb[i] = 1'b1;
                    n_we[i]  = 1'($urandom);
                    n_adr[i] = $urandom;
                    n_dat[i] = $urandom;
                end else begin
                    n_stb[i] = 1'b0;
                    n_we[i]  = 1'($urandom);
                    n_adr[i] = $urandom;
                end
            end
            n_rst = ($urandom % 400 == 0);
            slave_plan(1'b1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
